// File: rtl/riscv_aes_ctx_regfile_if.sv
// Bus bundle for the AES context register file: configuration writes, start,
// engine request/completion channel and status outputs.
interface riscv_aes_ctx_regfile_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STATE_WORDS = 4,
  parameter int unsigned KEY_WORDS   = 8,
  parameter int unsigned NUM_CTX     = 2
);
  localparam int unsigned CtxW  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int unsigned AddrW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  logic                              test_en_i;
  logic [CtxW-1:0]                   ctx_sel_i;
  logic [1:0]                        instruction_sel_i;
  logic [AddrW-1:0]                  waddr_i;
  logic [DATA_WIDTH-1:0]             wdata_i;
  logic                              wen_i;
  logic                              aes_start_i;
  logic                              eng_valid_o;
  logic                              eng_ready_i;
  logic [STATE_WORDS*DATA_WIDTH-1:0] eng_state_o;
  logic [KEY_WORDS*DATA_WIDTH-1:0]   eng_key_o;
  logic [1:0]                        eng_keylen_o;
  logic                              eng_done_i;
  logic [STATE_WORDS*DATA_WIDTH-1:0] eng_result_i;
  logic                              busy_o;
  logic                              done_o;
  logic [DATA_WIDTH-1:0]             wb_addr_o;
  logic                              wr_err_o;
  logic                              start_err_o;

  modport master (
    output test_en_i, ctx_sel_i, instruction_sel_i, waddr_i, wdata_i, wen_i, aes_start_i,
    output eng_ready_i, eng_done_i, eng_result_i,
    input  eng_valid_o, eng_state_o, eng_key_o, eng_keylen_o,
    input  busy_o, done_o, wb_addr_o, wr_err_o, start_err_o
  );

  modport slave (
    input  test_en_i, ctx_sel_i, instruction_sel_i, waddr_i, wdata_i, wen_i, aes_start_i,
    input  eng_ready_i, eng_done_i, eng_result_i,
    output eng_valid_o, eng_state_o, eng_key_o, eng_keylen_o,
    output busy_o, done_o, wb_addr_o, wr_err_o, start_err_o
  );
endinterface

// File: rtl/riscv_aes_ctx_regfile.sv
// Multi-context AES register file: holds state/key/keylen/writeback address per
// context and sequences one engine operation at a time (IDLE -> REQ -> RUN -> WB).
module riscv_aes_ctx_regfile #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STATE_WORDS = 4,
  parameter int unsigned KEY_WORDS   = 8,
  parameter int unsigned NUM_CTX     = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  riscv_aes_ctx_regfile_if.slave bus
);
  localparam int unsigned CtxW  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int unsigned AddrW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [CtxW:0] NumCtx = NUM_CTX[CtxW:0];

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {StIdle, StReq, StRun, StWb} fsm_e;

  word_t           state_q  [NUM_CTX][STATE_WORDS];
  word_t           state_d  [NUM_CTX][STATE_WORDS];
  word_t           key_q    [NUM_CTX][KEY_WORDS];
  word_t           key_d    [NUM_CTX][KEY_WORDS];
  logic [1:0]      keylen_q [NUM_CTX];
  logic [1:0]      keylen_d [NUM_CTX];
  word_t           wbaddr_q [NUM_CTX];
  word_t           wbaddr_d [NUM_CTX];
  fsm_e            fsm_q, fsm_d;
  logic [CtxW-1:0] act_q, act_d;
  word_t           wb_addr_q, wb_addr_d;
  logic            wr_err_q, wr_err_d;
  logic            start_err_q, start_err_d;

  logic            busy;
  logic            ctx_ok;
  logic            wr_act;
  logic            wr_ok;
  logic            ctx_hit;
  logic [CtxW-1:0] view;

  assign busy   = (fsm_q != StIdle);
  assign ctx_ok = ({1'b0, bus.ctx_sel_i} < NumCtx);
  // Writes aimed at the context the engine is working on are refused while busy.
  assign wr_act = bus.wen_i && ctx_ok && busy && (bus.ctx_sel_i == act_q);
  assign wr_ok  = bus.wen_i && ctx_ok && !wr_act && !bus.test_en_i;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    keylen_d = keylen_q;
    wbaddr_d = wbaddr_q;
    ctx_hit  = 1'b0;
    for (int c = 0; c < NUM_CTX; c++) begin
      ctx_hit = wr_ok && (bus.ctx_sel_i == CtxW'(c));
      for (int w = 0; w < STATE_WORDS; w++) begin
        if (ctx_hit && bus.instruction_sel_i == 2'd0 && bus.waddr_i == AddrW'(w)) begin
          state_d[c][w] = bus.wdata_i;
        end
      end
      for (int w = 0; w < KEY_WORDS; w++) begin
        if (ctx_hit && bus.instruction_sel_i == 2'd1 && bus.waddr_i == AddrW'(w)) begin
          key_d[c][w] = bus.wdata_i;
        end
      end
      if (ctx_hit && bus.instruction_sel_i == 2'd2 && bus.wdata_i < word_t'(3)) begin
        keylen_d[c] = bus.wdata_i[1:0];
      end
      if (ctx_hit && bus.instruction_sel_i == 2'd3) begin
        wbaddr_d[c] = bus.wdata_i;
      end
      if (fsm_q == StRun && bus.eng_done_i && act_q == CtxW'(c)) begin
        for (int w = 0; w < STATE_WORDS; w++) begin
          state_d[c][w] = bus.eng_result_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (bus.test_en_i) begin
        for (int w = 0; w < STATE_WORDS; w++) begin
          state_d[c][w] = '1;
        end
      end
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    act_d       = act_q;
    wb_addr_d   = wb_addr_q;
    wr_err_d    = wr_act;
    start_err_d = bus.aes_start_i && busy;
    unique case (fsm_q)
      StIdle: begin
        if (bus.aes_start_i && ctx_ok) begin
          fsm_d     = StReq;
          act_d     = bus.ctx_sel_i;
          wb_addr_d = wbaddr_q[bus.ctx_sel_i];
        end
      end
      StReq:   if (bus.eng_ready_i) fsm_d = StRun;
      StRun:   if (bus.eng_done_i) fsm_d = StWb;
      StWb:    fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        for (int w = 0; w < STATE_WORDS; w++) state_q[c][w] <= '0;
        for (int w = 0; w < KEY_WORDS; w++) key_q[c][w] <= '0;
        keylen_q[c] <= '0;
        wbaddr_q[c] <= '0;
      end
      fsm_q       <= StIdle;
      act_q       <= '0;
      wb_addr_q   <= '0;
      wr_err_q    <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      wbaddr_q    <= wbaddr_d;
      fsm_q       <= fsm_d;
      act_q       <= act_d;
      wb_addr_q   <= wb_addr_d;
      wr_err_q    <= wr_err_d;
      start_err_q <= start_err_d;
    end
  end

  assign view = busy ? act_q : '0;

  always_comb begin
    bus.eng_state_o = '0;
    bus.eng_key_o   = '0;
    for (int w = 0; w < STATE_WORDS; w++) begin
      bus.eng_state_o[w*DATA_WIDTH +: DATA_WIDTH] = state_q[view][w];
    end
    for (int w = 0; w < KEY_WORDS; w++) begin
      bus.eng_key_o[w*DATA_WIDTH +: DATA_WIDTH] = key_q[view][w];
    end
  end

  assign bus.eng_keylen_o = keylen_q[view];
  assign bus.eng_valid_o  = (fsm_q == StReq);
  assign bus.busy_o       = busy;
  assign bus.done_o       = (fsm_q == StWb);
  assign bus.wb_addr_o    = wb_addr_q;
  assign bus.wr_err_o     = wr_err_q;
  assign bus.start_err_o  = start_err_q;
endmodule
